// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding,
// default operand width and the busy decode used by the top level.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    function automatic logic is_busy(input logic [1:0] st);
        return (st == ST_SHIFT) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Parallel-word request/response bundle between a word-level client and the
// serial adder controller.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_ctrl_add_bit.sv
// One-bit full-adder slice assembled from two-input xor and nand gates;
// the carry is the majority function expressed as nand(nand(a,b), nand(ci,a^b)).
module serial_add_xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module serial_add_nand2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module serial_add_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    logic p_s;
    logic n_ab_s;
    logic n_cp_s;

    serial_add_xor2  u_x0 (.a_i(a_i),    .b_i(b_i),    .y_o(p_s));
    serial_add_xor2  u_x1 (.a_i(p_s),    .b_i(ci_i),   .y_o(s_o));
    serial_add_nand2 u_n0 (.a_i(a_i),    .b_i(b_i),    .y_o(n_ab_s));
    serial_add_nand2 u_n1 (.a_i(ci_i),   .b_i(p_s),    .y_o(n_cp_s));
    serial_add_nand2 u_n2 (.a_i(n_ab_s), .b_i(n_cp_s), .y_o(co_o));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencing controller for the bit-serial adder: loads operands on start,
// shifts them LSB-first through one full-adder slice, then pulses done.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                cp,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             done_q,   done_d;

    logic             slice_s;
    logic             slice_co;

    serial_add_bit u_bit (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .ci_i (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // Next-state and datapath decode for IDLE / SHIFT / DONE
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                carry_d  = slice_co;
                sum_sr_d = {slice_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                // The last shift is the one that also raises done.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, updated on the falling edge of cp
    always_ff @(negedge cp) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = is_busy(state_q);
    assign bus.done = done_q;
    assign bus.sum  = sum_sr_q;
    assign bus.cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 scenarios plus
// an exhaustive WIDTH=4 sweep on a second instance).
module tb_serial_adder_ctrl;

    logic cp;
    logic rst;
    int   errors;
    int   checks;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.cp(cp), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (.cp(cp), .rst(rst), .bus(bus4));

    initial begin
        cp = 1'b1;
        forever #5 cp = ~cp;
    end

    // Issue one WIDTH=8 addition; reports latency in cycles after the accepting edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output int lat, output logic busy0,
                          output logic [7:0] s, output logic c,
                          output logic done_after, output logic busy_after);
        @(posedge cp);
        bus8.start = 1'b1; bus8.a = av; bus8.b = bv; bus8.cin = cv;
        @(posedge cp);
        bus8.start = 1'b0; bus8.a = ~av; bus8.b = ~bv; bus8.cin = ~cv;
        busy0 = bus8.busy;
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            @(posedge cp);
            lat++;
        end
        s = bus8.sum;
        c = bus8.cout;
        @(posedge cp);
        done_after = bus8.done;
        busy_after = bus8.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge cp);
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus8.done); end
        checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", bus8.sum); end
        checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus8.cout); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic b0, c, da, ba; logic [7:0] s;
        issue8(8'h35, 8'h0A, 1'b0, lat, b0, s, c, da, ba);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got=%b exp=1", b0); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (s !== 8'h3F) begin errors++; $display("FAIL basic_sum got=%h exp=3f", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", c); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", da); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b exp=0", ba); end
        checks++; if (bus8.sum !== 8'h3F) begin errors++; $display("FAIL basic_sum_hold got=%h exp=3f", bus8.sum); end
    endtask

    task automatic test_carry();
        int lat; logic b0, c, da, ba; logic [7:0] s;
        issue8(8'hFF, 8'h01, 1'b0, lat, b0, s, c, da, ba);
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL ripple_sum got=%h exp=00", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b exp=1", c); end
        issue8(8'hFF, 8'hFF, 1'b1, lat, b0, s, c, da, ba);
        checks++; if (s !== 8'hFF) begin errors++; $display("FAIL max_sum got=%h exp=ff", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL max_cout got=%b exp=1", c); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL max_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_ignored_start();
        int cyc; int lat; logic b0, c, da, ba; logic [7:0] s;
        @(posedge cp);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
        @(posedge cp);
        bus8.start = 1'b0;
        repeat (2) @(posedge cp);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
        @(posedge cp);
        bus8.start = 1'b0;
        cyc = 3;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            @(posedge cp);
            cyc++;
        end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL ign_latency got=%0d exp=8", cyc); end
        checks++; if (bus8.sum !== 8'h30) begin errors++; $display("FAIL ign_sum got=%h exp=30", bus8.sum); end
        bus8.start = 1'b1;
        @(posedge cp);
        bus8.start = 1'b0;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL ign_done_start_busy got=%b exp=0", bus8.busy); end
        @(posedge cp);
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL ign_not_queued got=%b exp=0", bus8.busy); end
        checks++; if (bus8.sum !== 8'h30) begin errors++; $display("FAIL ign_sum_hold got=%h exp=30", bus8.sum); end
        issue8(8'h01, 8'h01, 1'b0, lat, b0, s, c, da, ba);
        checks++; if (s !== 8'h02) begin errors++; $display("FAIL ign_later_sum got=%h exp=02", s); end
    endtask

    task automatic test_reset_mid();
        int pulses; int lat; logic b0, c, da, ba; logic [7:0] s;
        @(posedge cp);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
        @(posedge cp);
        bus8.start = 1'b0;
        repeat (3) @(posedge cp);
        rst = 1'b1;
        @(posedge cp);
        rst = 1'b0;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%h exp=00", bus8.sum); end
        checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", bus8.cout); end
        pulses = 0;
        repeat (12) begin
            @(posedge cp);
            if (bus8.done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        issue8(8'h7F, 8'h01, 1'b0, lat, b0, s, c, da, ba);
        checks++; if (s !== 8'h80) begin errors++; $display("FAIL midrst_after_sum got=%h exp=80", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL midrst_after_cout got=%b exp=0", c); end
    endtask

    task automatic test_rst_start();
        @(posedge cp);
        rst = 1'b1; bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22;
        @(posedge cp);
        rst = 1'b0; bus8.start = 1'b0;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rststart_busy got=%b exp=0", bus8.busy); end
        @(posedge cp);
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rststart_idle got=%b exp=0", bus8.busy); end
        checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL rststart_sum got=%h exp=00", bus8.sum); end
    endtask

    task automatic test_sweep4();
        int cyc;
        logic [4:0] exp;
        logic [4:0] got;
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    exp = 5'(av + bv + cv);
                    @(posedge cp);
                    bus4.start = 1'b1; bus4.a = 4'(av); bus4.b = 4'(bv); bus4.cin = cv[0];
                    @(posedge cp);
                    bus4.start = 1'b0; bus4.a = 4'(~av); bus4.b = 4'(~bv); bus4.cin = ~cv[0];
                    cyc = 0;
                    while (bus4.done !== 1'b1 && cyc < 20) begin
                        @(posedge cp);
                        cyc++;
                    end
                    got = {bus4.cout, bus4.sum};
                    checks++;
                    if (got !== exp || cyc !== 4) begin
                        errors++;
                        $display("FAIL sweep4 a=%0d b=%0d cin=%0d got=%h lat=%0d exp=%h lat=4", av, bv, cv, got, cyc, exp);
                    end
                    @(posedge cp);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.a = 4'h0;  bus4.b = 4'h0;  bus4.cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_ignored_start();
        test_reset_mid();
        test_rst_start();
        test_sweep4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencing controller for the bit-serial adder datapath. It accepts two WIDTH-bit operands plus a carry-in on a start pulse and feeds them LSB-first through a one-bit full-adder slice with a registered carry. It assembles the serial sum bits into a parallel result and pulses `done` when the result is valid. It sits between parallel-word logic and the serial adder, so parallel consumers can use the serial datapath without handling bit-level timing.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits; must be ≥ 2.

Ports:
- `cp`  in  1  clock; all state updates on the falling edge of `cp`, matching the team's flip-flop convention.
- `rst`  in  1  reset; synchronous and active-high, sampled on the falling edge of `cp`.
- `start`  in  1  request a new addition; accepted only in IDLE.
- `a`  in  WIDTH  operand A; sampled on the accepting edge only.
- `b`  in  WIDTH  operand B; sampled on the accepting edge only.
- `cin`  in  1  carry-in; sampled on the accepting edge only.
- `busy`  out  1  high in SHIFT and DONE; decoded from the state register.
- `done`  out  1  registered one-cycle pulse; `sum`/`cout` valid.
- `sum`  out  WIDTH  result; holds its value until the next accepted start or reset.
- `cout`  out  1  final carry; holds its value like `sum`.

## Operation
- State machine with three states:
  - IDLE: if `start`, load `a`/`b` into operand shift registers, carry ← `cin`, bit counter ← 0, sum shift register ← 0; go to SHIFT.
  - SHIFT, each edge:
    - z = a_sr[0] ^ b_sr[0] ^ carry.
    - carry ← majority(a_sr[0], b_sr[0], carry).
    - sum_sr ← {z, sum_sr[WIDTH-1:1]}.
    - Operand registers shift right with 0 fill; counter increments.
    - On the edge where counter == WIDTH-1 (the WIDTH-th shift): go to DONE, `done` ← 1.
  - DONE: `done` ← 0; go to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored and is not queued.
- `sum` drives sum_sr; `cout` drives the carry register. Both are stable from the `done` cycle onward.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH).

## Timing
- Reset (highest priority, overrides `start` on the same edge):
  - State ← IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - Shift registers and counter ← 0.
- Reset mid-operation aborts the addition; no `done` is produced.
- Start accepted on edge k: `busy` rises after edge k. WIDTH shifts occur on edges k+1 … k+WIDTH.
- `done` is high for exactly the cycle after edge k+WIDTH.
- `busy` falls after edge k+WIDTH+1.
- Minimum start-to-start spacing: WIDTH+2 edges.
- Operand inputs may change freely after the accepting edge.

## Structure
- Shared package/include `serial_adder_pkg`:
  - State encoding localparams: IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10.
  - Default WIDTH constant.
- Sub-module `serial_add_bit`: purely combinational full-adder slice (a, b, ci → s, co), built from the team's xor/nand gate modules.
- The controller owns the carry register and all sequencing.

## Test plan
Unless noted, WIDTH = 8.
- `a`=8'h35, `b`=8'h0A, `cin`=0 → `sum`=8'h3F, `cout`=0; `done` high exactly one cycle, 8 edges after the accepting edge.
- `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1 (full carry ripple across all bits).
- `a`=8'hFF, `b`=8'hFF, `cin`=1 → `sum`=8'hFF, `cout`=1.
- Start 8'h10+8'h20, then pulse `start` with 8'h01+8'h01 during SHIFT and during DONE:
  - Result is 8'h30.
  - The second request is ignored.
  - A later start in IDLE with 8'h01+8'h01 yields 8'h02.
- Assert `rst` on the 4th shift edge:
  - Next cycle: `busy`=0, `sum`=0, `cout`=0.
  - No `done` pulse appears.
  - A subsequent 8'h7F+8'h01 yields 8'h80, `cout`=0.
- `rst` and `start` high on the same edge → stays IDLE, `busy`=0. Also run a WIDTH=4 sweep over all 512 operand/cin combinations against a+b+cin.
